// File: rtl/engck_pkg.sv
// Shared types for the engine-clock phase sync controller.
// Frame phase and generator sync share one 2-bit type.
package engck_pkg;

    localparam int ENGCK_PHASE_W = 2;

    typedef logic [ENGCK_PHASE_W-1:0] engck_phase_t;

    typedef enum logic [1:0] {
        HOLD,
        ACQUIRE,
        LOCKED
    } engck_state_t;

    // Last phase of a frame; sync changes are applied only when leaving it.
    localparam engck_phase_t ENGCK_FRAME_LAST = engck_phase_t'(3);

endpackage

// File: rtl/engck_ref_watchdog.sv
// Saturating strobe watchdog: counts cycles since the last reference strobe
// and flags no_ref while the count sits at all-ones.
module engck_ref_watchdog #(
    parameter int TIMEOUT_W = 12
) (
    input  logic engclk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic no_ref
);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 no_ref_q, no_ref_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            if (clear) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
        end
        no_ref_d = (cnt_d == '1);
    end

    always_ff @(posedge engclk) begin
        if (rst) begin
            cnt_q    <= '0;
            no_ref_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            no_ref_q <= no_ref_d;
        end
    end

    assign no_ref = no_ref_q;

endmodule

// File: rtl/engck_phase_sync_ctl.sv
// Sequences the 4-phase clock generator out of reset and steers its phase
// select so the divide-by-4 frame lines up with the system reference strobe.
module engck_phase_sync_ctl
    import engck_pkg::*;
#(
    parameter int RST_HOLD  = 8,
    parameter int LOCK_CNT  = 4,
    parameter int TIMEOUT_W = 12
) (
    input  logic       engclk,
    input  logic       rst,
    input  logic       ref_strobe,
    input  logic       relock_req,
    output logic       gen_rstb,
    output logic [1:0] sync,
    output logic       locked,
    output logic       err_pulse,
    output logic       no_ref,
    output logic [1:0] phase
);

    localparam int HOLD_W  = $clog2(RST_HOLD + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

    engck_state_t        state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    engck_phase_t        phase_q, phase_d;
    logic                gen_rstb_q, gen_rstb_d;
    engck_phase_t        sync_q, sync_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    engck_phase_t        cand_q, cand_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic                pend_valid_q, pend_valid_d;
    engck_phase_t        pending_q, pending_d;
    logic                restart;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        gen_rstb_d   = gen_rstb_q;
        sync_d       = sync_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        cand_d       = cand_q;
        match_d      = match_q;
        pend_valid_d = pend_valid_q;
        pending_d    = pending_q;
        restart      = 1'b0;
        phase_d      = (state_q == HOLD) ? '0 : phase_q + engck_phase_t'(1);

        case (state_q)
            HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_d == HOLD_LAST) begin
                    gen_rstb_d = 1'b1;
                    state_d    = ACQUIRE;
                end
            end

            ACQUIRE: begin
                if (relock_req) begin
                    locked_d     = 1'b0;
                    pend_valid_d = 1'b0;
                    match_d      = '0;
                end else begin
                    if (ref_strobe && (match_q == '0 || phase_q != cand_q)) begin
                        restart      = 1'b1;
                        cand_d       = phase_q;
                        match_d      = MATCH_W'(1);
                        pend_valid_d = 1'b0;
                    end else if (ref_strobe && match_q != MATCH_MAX) begin
                        match_d = match_q + MATCH_W'(1);
                    end
                    if (ref_strobe && match_d == MATCH_MAX) begin
                        pend_valid_d = 1'b1;
                        pending_d    = cand_d;
                    end
                    // A disagreeing strobe in the boundary cycle cancels the apply.
                    if (pend_valid_q && phase_q == ENGCK_FRAME_LAST && !restart) begin
                        sync_d       = pending_q;
                        locked_d     = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = LOCKED;
                    end
                end
            end

            LOCKED: begin
                if (relock_req) begin
                    locked_d     = 1'b0;
                    pend_valid_d = 1'b0;
                    match_d      = '0;
                    state_d      = ACQUIRE;
                end else if (ref_strobe && phase_q != sync_q) begin
                    err_pulse_d = 1'b1;
                    locked_d    = 1'b0;
                    state_d     = ACQUIRE;
                    cand_d      = phase_q;
                    match_d     = MATCH_W'(1);
                    if (MATCH_MAX == MATCH_W'(1)) begin
                        pend_valid_d = 1'b1;
                        pending_d    = phase_q;
                    end
                end
            end

            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge engclk) begin
        if (rst) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            phase_q      <= '0;
            gen_rstb_q   <= 1'b0;
            sync_q       <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            cand_q       <= '0;
            match_q      <= '0;
            pend_valid_q <= 1'b0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            phase_q      <= phase_d;
            gen_rstb_q   <= gen_rstb_d;
            sync_q       <= sync_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            pend_valid_q <= pend_valid_d;
            pending_q    <= pending_d;
        end
    end

    engck_ref_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .engclk (engclk),
        .rst    (rst),
        .clear  (ref_strobe),
        .enable (state_q != HOLD),
        .no_ref (no_ref)
    );

    assign gen_rstb  = gen_rstb_q;
    assign sync      = sync_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_engck_phase_sync_ctl.sv
// Directed bench for engck_phase_sync_ctl with RST_HOLD=8, LOCK_CNT=4, TIMEOUT_W=4.
module tb_engck_phase_sync_ctl;

    logic       engclk = 1'b0;
    logic       rst;
    logic       ref_strobe;
    logic       relock_req;
    logic       gen_rstb;
    logic [1:0] sync;
    logic       locked;
    logic       err_pulse;
    logic       no_ref;
    logic [1:0] phase;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] ph;

    engck_phase_sync_ctl #(
        .RST_HOLD  (8),
        .LOCK_CNT  (4),
        .TIMEOUT_W (4)
    ) dut (
        .engclk     (engclk),
        .rst        (rst),
        .ref_strobe (ref_strobe),
        .relock_req (relock_req),
        .gen_rstb   (gen_rstb),
        .sync       (sync),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .no_ref     (no_ref),
        .phase      (phase)
    );

    always #5 engclk = ~engclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ph is the bench's own frame-phase model, advanced once per clock.
    task automatic tick();
        @(posedge engclk);
        #1;
        ph = ph + 2'd1;
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        ref_strobe = s;
        relock_req = r;
        tick();
        ref_strobe = 1'b0;
        relock_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobeAt(input logic [1:0] p);
        idle(4);
        while (ph != p) tick();
        checkOutput("phase_at_strobe", phase, p);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic expectLockAtBoundary(input string tag, input logic [1:0] exp_sync);
        while (ph != 2'd3) begin
            checkOutput({tag, "_pre_lock"}, locked, 0);
            tick();
        end
        checkOutput({tag, "_pre_lock"}, locked, 0);
        tick();
        checkOutput({tag, "_locked"}, locked, 1);
        checkOutput({tag, "_sync"}, sync, exp_sync);
        checkOutput({tag, "_err"}, err_pulse, 0);
    endtask

    task automatic resetAndRelease(input string tag);
        rst = 1'b1;
        tick();
        checkOutput({tag, "_gen_rstb"}, gen_rstb, 0);
        checkOutput({tag, "_sync"}, sync, 0);
        checkOutput({tag, "_locked"}, locked, 0);
        checkOutput({tag, "_err"}, err_pulse, 0);
        checkOutput({tag, "_no_ref"}, no_ref, 0);
        checkOutput({tag, "_phase"}, phase, 0);
        rst = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput({tag, "_hold_gen_rstb"}, gen_rstb, 0);
            checkOutput({tag, "_hold_phase"}, phase, 0);
        end
        tick();
        ph = 2'd0;
        checkOutput({tag, "_release_gen_rstb"}, gen_rstb, 1);
        checkOutput({tag, "_release_phase"}, phase, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput({tag, "_phase_count"}, phase, i % 4);
        end
    endtask

    initial begin
        ref_strobe = 1'b0;
        relock_req = 1'b0;
        ph         = 2'd0;

        resetAndRelease("reset");

        // Four strobes at phase 2 lock sync=2 at the next frame boundary.
        for (int i = 0; i < 4; i++) begin
            strobeAt(2'd2);
            checkOutput("acq2_locked", locked, 0);
            checkOutput("acq2_err", err_pulse, 0);
        end
        expectLockAtBoundary("acq2", 2'd2);
        checkOutput("acq2_no_ref", no_ref, 0);

        // Offset disagreement while locked, then relock at phase 1.
        strobeAt(2'd1);
        checkOutput("err_pulse_set", err_pulse, 1);
        checkOutput("err_locked_drop", locked, 0);
        checkOutput("err_sync_held", sync, 2);
        tick();
        checkOutput("err_pulse_single", err_pulse, 0);
        for (int i = 0; i < 3; i++) begin
            strobeAt(2'd1);
            checkOutput("relock1_locked", locked, 0);
            checkOutput("relock1_sync_held", sync, 2);
        end
        expectLockAtBoundary("relock1", 2'd1);

        // Offsets 2,2,3,3,3,3: the candidate restarts on the first 3.
        applyStimulus(1'b0, 1'b1);
        checkOutput("relock_req_locked", locked, 0);
        strobeAt(2'd2);
        strobeAt(2'd2);
        strobeAt(2'd3);
        strobeAt(2'd3);
        strobeAt(2'd3);
        idle(8);
        checkOutput("restart_no_lock", locked, 0);
        checkOutput("restart_sync_held", sync, 1);
        strobeAt(2'd3);
        expectLockAtBoundary("restart3", 2'd3);

        // relock_req and ref_strobe together: the strobe must not count.
        idle(4);
        while (ph != 2'd0) tick();
        applyStimulus(1'b1, 1'b1);
        checkOutput("relock_strobe_locked", locked, 0);
        checkOutput("relock_strobe_err", err_pulse, 0);
        for (int i = 0; i < 3; i++) strobeAt(2'd0);
        idle(8);
        checkOutput("relock_strobe_not_counted", locked, 0);
        checkOutput("relock_strobe_sync_held", sync, 3);
        strobeAt(2'd0);
        expectLockAtBoundary("relock0", 2'd0);

        // Matching strobe while locked, then let the watchdog expire.
        strobeAt(2'd0);
        checkOutput("match_locked", locked, 1);
        checkOutput("match_err", err_pulse, 0);
        idle(14);
        checkOutput("wd_before_expiry", no_ref, 0);
        tick();
        checkOutput("wd_expired", no_ref, 1);
        checkOutput("wd_flywheel_locked", locked, 1);
        idle(2);
        checkOutput("wd_saturated", no_ref, 1);
        while (ph != 2'd0) tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("wd_cleared", no_ref, 0);
        checkOutput("wd_clear_locked", locked, 1);
        checkOutput("wd_clear_err", err_pulse, 0);

        // Reset in the middle of acquisition.
        applyStimulus(1'b0, 1'b1);
        strobeAt(2'd1);
        checkOutput("mid_acq_locked", locked, 0);
        resetAndRelease("mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
